// File: rtl/rv32_mem_arbiter_if.sv
// rv32_mem_arbiter_if: fetch, load/store and memory bus signals of the priRV32 memory arbiter
interface rv32_mem_arbiter_if;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_be;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: single-outstanding arbiter of fetch and load/store onto one memory bus
module rv32_mem_arbiter #(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    rv32_mem_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] SMAX  = SW'(MAX_STREAK);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
    state_t        st;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          own, if_err_q, ls_err_q;
    logic [31:0]   if_rdata_q, ls_rdata_q, rv;
    logic          idle, ls_win, done, abort, fin;
    // grants and completions are decoded in-cycle so gnt->mem_req->rvalid fits in three cycles
    always_comb begin
        idle          = st == IDLE;
        ls_win        = bus.ls_req && (!bus.if_req || streak < SMAX);
        bus.ls_gnt    = reset && idle && ls_win;
        bus.if_gnt    = reset && idle && bus.if_req && !ls_win;
        done          = st == RESP && bus.mem_rvalid;
        abort         = tcnt == TLAST && (st == ADDR ? !bus.mem_ready : st == RESP && !bus.mem_rvalid);
        fin           = done || abort;
        bus.ls_rvalid = fin && own;
        bus.if_rvalid = fin && !own;
        rv            = (abort || bus.mem_we) ? '0 : bus.mem_rdata;
        bus.ls_rdata  = bus.ls_rvalid ? rv : ls_rdata_q;
        bus.ls_err    = bus.ls_rvalid ? abort : ls_err_q;
        bus.if_rdata  = bus.if_rvalid ? rv : if_rdata_q;
        bus.if_err    = bus.if_rvalid ? abort : if_err_q;
        bus.mem_req   = st == ADDR;
        busy          = !idle;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= IDLE;
            streak        <= '0;
            tcnt          <= '0;
            own           <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            if_rdata_q    <= '0;
            ls_rdata_q    <= '0;
            if_err_q      <= 1'b0;
            ls_err_q      <= 1'b0;
        end else begin
            if (bus.ls_gnt || bus.if_gnt) begin
                st            <= ADDR;
                own           <= bus.ls_gnt;
                bus.mem_we    <= bus.ls_gnt && bus.ls_we;
                bus.mem_addr  <= bus.ls_gnt ? bus.ls_addr : bus.if_addr;
                bus.mem_wdata <= bus.ls_gnt ? bus.ls_wdata : '0;
                bus.mem_be    <= bus.ls_gnt ? bus.ls_be : 4'hF;
                streak        <= (bus.if_gnt || !bus.if_req) ? '0 : (streak == SMAX ? SMAX : streak + 1'b1);
            end else if (st == ADDR && bus.mem_ready) begin
                st   <= RESP;
                tcnt <= '0;
            end else if (fin) begin
                st   <= IDLE;
                tcnt <= '0;
            end else if (!idle) begin
                tcnt <= tcnt + 1'b1;
            end
            if (bus.ls_rvalid) begin
                ls_rdata_q <= rv;
                ls_err_q   <= abort;
            end
            if (bus.if_rvalid) begin
                if_rdata_q <= rv;
                if_err_q   <= abort;
            end
        end
    end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: directed stimulus with a queue-based scoreboard checking grants and completions
module tb_rv32_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0, bad = 0, cyc = 0;
    bit   resp_en = 1'b1, hold_rv = 1'b0, pend = 1'b0;
    int   inj_req = 0, inj_done = 0;
    logic [31:0] paddr;
    typedef struct {bit ls; logic [31:0] d; bit e;} rsp_t;
    rsp_t rq[$];
    bit   gq[$];
    rv32_mem_arbiter_if b();
    rv32_mem_arbiter dut (.clk(clk), .reset(rst_n), .bus(b), .busy(busy));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : a ^ 32'hA5A5_0000;
    endfunction
    task automatic wait_gnt(input bit ls, output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ls ? b.ls_gnt : b.if_gnt) begin
                c = cyc;
                break;
            end
        end
        chk("gnt_seen", ls ? b.ls_gnt : b.if_gnt, 1);
    endtask
    task automatic ls_drive(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        b.ls_we = we; b.ls_addr = a; b.ls_wdata = wd; b.ls_be = be; b.ls_req = 1'b1;
    endtask
    // memory model: zero-wait ready, response next cycle; can stall or inject a stray response
    initial begin
        b.mem_ready = 1'b0; b.mem_rvalid = 1'b0; b.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            b.mem_ready = 1'b0; b.mem_rvalid = 1'b0;
            if (!rst_n) pend = 1'b0;
            else if (inj_req != inj_done) begin
                b.mem_rvalid = 1'b1; b.mem_rdata = 32'h1234_5678; inj_done = inj_req;
            end else if (pend) begin
                if (!hold_rv) begin
                    b.mem_rvalid = 1'b1; b.mem_rdata = mem_fn(paddr); pend = 1'b0;
                end
            end else if (b.mem_req && resp_en) begin
                b.mem_ready = 1'b1; pend = 1'b1; paddr = b.mem_addr;
            end
        end
    end
    always @(negedge clk) begin
        if (b.if_gnt || b.ls_gnt) begin
            chk("gnt_one_hot", {31'b0, b.if_gnt && b.ls_gnt}, 0);
            chk("gnt_rv_excl", {31'b0, b.if_rvalid || b.ls_rvalid}, 0);
            chk("gnt_expected", {31'b0, gq.size() != 0}, 1);
            if (gq.size() != 0) chk("gnt_port", {31'b0, b.ls_gnt}, {31'b0, gq.pop_front()});
        end
        if (b.if_rvalid || b.ls_rvalid) begin
            chk("rv_one_hot", {31'b0, b.if_rvalid && b.ls_rvalid}, 0);
            chk("rv_expected", {31'b0, rq.size() != 0}, 1);
            if (rq.size() != 0) begin
                automatic rsp_t r = rq.pop_front();
                chk("rv_port", {31'b0, b.ls_rvalid}, {31'b0, r.ls});
                chk("rv_data", b.ls_rvalid ? b.ls_rdata : b.if_rdata, r.d);
                chk("rv_err", {31'b0, b.ls_rvalid ? b.ls_err : b.if_err}, {31'b0, r.e});
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int c, c1, c2, n;
        b.if_req = 1'b1; b.if_addr = 32'h100;
        ls_drive(1'b1, 32'h40, 32'h1, 4'h1);
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_req", {31'b0, b.mem_req}, 0);
        chk("rst_mem_addr", b.mem_addr, 0);
        chk("rst_mem_be", {28'b0, b.mem_be}, 0);
        chk("rst_gnt", {30'b0, b.if_gnt, b.ls_gnt}, 0);
        chk("rst_rvalid", {30'b0, b.if_rvalid, b.ls_rvalid}, 0);
        chk("rst_rdata", b.if_rdata | b.ls_rdata, 0);
        b.if_req = 1'b0; b.ls_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        // fetch read, zero-wait memory
        b.if_addr = 32'h100; b.if_req = 1'b1;
        gq.push_back(1'b0); rq.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        wait_gnt(1'b0, c);
        @(posedge clk); #1 b.if_req = 1'b0;
        @(negedge clk);
        chk("t1_mem_req", {31'b0, b.mem_req}, 1);
        chk("t1_mem_addr", b.mem_addr, 32'h100);
        chk("t1_mem_we_be", {27'b0, b.mem_we, b.mem_be}, 32'hF);
        chk("t1_gnt_pulse", {31'b0, b.if_gnt}, 0);
        @(negedge clk);
        chk("t1_rvalid_n2", {31'b0, b.if_rvalid}, 1);
        chk("t1_mem_req_off", {31'b0, b.mem_req}, 0);
        // back-to-back store then load
        @(posedge clk); #1;
        ls_drive(1'b1, 32'h2004, 32'h55AA, 4'b0011);
        gq.push_back(1'b1); rq.push_back('{1'b1, 32'h0, 1'b0});
        wait_gnt(1'b1, c1);
        @(posedge clk); #1;
        ls_drive(1'b0, 32'h2008, 32'h0, 4'hF);
        gq.push_back(1'b1); rq.push_back('{1'b1, 32'hA5A52008, 1'b0});
        @(negedge clk);
        chk("t2_mem_we", {31'b0, b.mem_we}, 1);
        chk("t2_mem_addr", b.mem_addr, 32'h2004);
        chk("t2_mem_wdata", b.mem_wdata, 32'h55AA);
        chk("t2_mem_be", {28'b0, b.mem_be}, 32'h3);
        wait_gnt(1'b1, c2);
        @(posedge clk); #1 b.ls_req = 1'b0;
        chk("t2_gap", c2 - c1, 3);
        @(negedge clk);
        chk("t2_load_addr", b.mem_addr, 32'h2008);
        chk("t2_load_we", {31'b0, b.mem_we}, 0);
        repeat (3) @(posedge clk); #1;
        // starvation: both held, LS x4 then IF, twice
        b.if_addr = 32'h300; b.if_req = 1'b1;
        ls_drive(1'b0, 32'h400, 32'h0, 4'hF);
        for (int k = 0; k < 10; k++) begin
            gq.push_back(k % 5 != 4);
            rq.push_back('{k % 5 != 4, (k % 5 != 4) ? 32'hA5A50400 : 32'hA5A50300, 1'b0});
        end
        n = 0;
        for (int i = 0; i < 100 && n < 10; i++) begin
            @(negedge clk);
            if (b.if_gnt || b.ls_gnt) n++;
        end
        chk("t3_grants", n, 10);
        @(posedge clk); #1 b.if_req = 1'b0; b.ls_req = 1'b0;
        repeat (4) @(posedge clk); #1;
        // timeout with a dead memory, then a stray late response
        resp_en = 1'b0;
        ls_drive(1'b0, 32'h500, 32'h0, 4'hF);
        gq.push_back(1'b1); rq.push_back('{1'b1, 32'h0, 1'b1});
        wait_gnt(1'b1, c);
        @(posedge clk); #1 b.ls_req = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("t4_no_early_abort", {31'b0, b.ls_rvalid}, 0);
        @(negedge clk);
        chk("t4_abort_rvalid", {31'b0, b.ls_rvalid}, 1);
        chk("t4_abort_err", {31'b0, b.ls_err}, 1);
        chk("t4_abort_rdata", b.ls_rdata, 0);
        @(negedge clk);
        chk("t4_mem_req_off", {31'b0, b.mem_req}, 0);
        chk("t4_idle", {31'b0, busy}, 0);
        @(negedge clk);
        inj_req++;
        @(negedge clk);
        chk("t4_late_dropped", {30'b0, b.if_rvalid, b.ls_rvalid}, 0);
        chk("t4_err_hold", {31'b0, b.ls_err}, 1);
        resp_en = 1'b1;
        // reset while waiting in RESP
        @(posedge clk); #1;
        hold_rv = 1'b1; b.if_addr = 32'h600; b.if_req = 1'b1;
        gq.push_back(1'b0);
        wait_gnt(1'b0, c);
        @(posedge clk); #1 b.if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_resp", {31'b0, busy}, 1);
        b.if_addr = 32'h700; b.if_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'b0, busy}, 0);
        chk("t5_rst_mem_req", {31'b0, b.mem_req}, 0);
        chk("t5_rst_gnt", {30'b0, b.if_gnt, b.ls_gnt}, 0);
        chk("t5_rst_rvalid", {30'b0, b.if_rvalid, b.ls_rvalid}, 0);
        chk("t5_rst_mem_addr", b.mem_addr, 0);
        @(posedge clk); #3;
        hold_rv = 1'b0;
        gq.push_back(1'b0); rq.push_back('{1'b0, 32'hA5A50700, 1'b0});
        rst_n = 1'b1;
        wait_gnt(1'b0, c);
        @(posedge clk); #1 b.if_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("gq_empty", gq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
